// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator (I/S/B/U/J) feeding a 2-entry skid buffer.
// Optional IMM_GEN_SHAMT_EN: shift-immediate opcodes yield only the zero-extended shamt.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     inst_out,
    output logic [XLEN-1:0] imm_out,
    output logic [2:0]      imm_type
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef enum logic [1:0] {EMPTY, ONE, FULL} count_t;

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;

    count_t          count_reg;
    logic [31:0]     inst_reg [2];
    logic [XLEN-1:0] imm_reg  [2];
    logic [2:0]      type_reg [2];

    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type;
    logic            push;
    logic            pop;

    always_comb begin
        dec_imm32 = '0;
        dec_type  = T_NONE;
        unique case (inst_in[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                dec_imm32 = {{20{inst_in[31]}}, inst_in[31:20]};
                dec_type  = T_I;
            end
            7'b0100011: begin
                dec_imm32 = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
                dec_type  = T_S;
            end
            7'b1100011: begin
                dec_imm32 = {{19{inst_in[31]}}, inst_in[31], inst_in[7],
                             inst_in[30:25], inst_in[11:8], 1'b0};
                dec_type  = T_B;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm32 = {inst_in[31:12], 12'b0};
                dec_type  = T_U;
            end
            7'b1101111: begin
                dec_imm32 = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12],
                             inst_in[20], inst_in[30:21], 1'b0};
                dec_type  = T_J;
            end
            default: begin
                dec_imm32 = '0;
                dec_type  = T_NONE;
            end
        endcase
        dec_imm = XLEN'($signed(dec_imm32));
`ifdef IMM_GEN_SHAMT_EN
        // slli/srli/srai: keep only the shift amount, dropping funct7
        if (inst_in[6:0] == 7'b0010011 && inst_in[13:12] == 2'b01) begin
            dec_imm = (XLEN == 64) ? XLEN'(inst_in[25:20]) : XLEN'(inst_in[24:20]);
        end
`endif
    end

    // Ready/valid depend only on registered occupancy, never on out_ready.
    assign in_ready  = (count_reg != FULL);
    assign out_valid = (count_reg != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign inst_out = inst_reg[0];
    assign imm_out  = imm_reg[0];
    assign imm_type = type_reg[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= EMPTY;
            for (int i = 0; i < 2; i++) begin
                inst_reg[i] <= '0;
                imm_reg[i]  <= '0;
                type_reg[i] <= '0;
            end
        end else if (flush) begin
            count_reg <= EMPTY;
        end else begin
            unique case (count_reg)
                EMPTY: begin
                    if (push) begin
                        inst_reg[0] <= inst_in;
                        imm_reg[0]  <= dec_imm;
                        type_reg[0] <= dec_type;
                        count_reg   <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        inst_reg[0] <= inst_in;
                        imm_reg[0]  <= dec_imm;
                        type_reg[0] <= dec_type;
                    end else if (push) begin
                        inst_reg[1] <= inst_in;
                        imm_reg[1]  <= dec_imm;
                        type_reg[1] <= dec_type;
                        count_reg   <= FULL;
                    end else if (pop) begin
                        count_reg   <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        inst_reg[0] <= inst_reg[1];
                        imm_reg[0]  <= imm_reg[1];
                        type_reg[0] <= type_reg[1];
                        count_reg   <= ONE;
                    end
                end
                default: count_reg <= EMPTY;
            endcase
        end
    end

endmodule
